// File: rtl/instruction_memory_ctrl.sv
// Byte-addressed instruction memory with a valid/ready fetch port, a 2-entry response
// queue, alignment/range fault reporting, a byte-enabled load port and a pipeline flush.
module instruction_memory_ctrl #(
    parameter int unsigned      XLEN        = 32,
    parameter int unsigned      DEPTH_BYTES = 4096,
    parameter logic [XLEN-1:0]  ADDR_BASE   = '0,
    parameter bit               ALIGN_CHECK = 1'b1,
    parameter string            INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    input  logic [XLEN-1:0]      fetch_addr,
    input  logic                 flush,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_instr,
    output logic [XLEN-1:0]      resp_addr,
    output logic [1:0]           resp_fault,
    input  logic                 load_en,
    input  logic [XLEN-1:0]      load_addr,
    input  logic [XLEN-1:0]      load_data,
    input  logic [XLEN/8-1:0]    load_be
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    localparam logic [XLEN:0] BASE_X  = {1'b0, ADDR_BASE};
    localparam logic [XLEN:0] DEPTH_X = (XLEN+1)'(DEPTH_BYTES);
    localparam logic [XLEN:0] LAST_X  = (XLEN+1)'(DEPTH_BYTES - NB);

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] addr;
        logic [1:0]      fault;
    } entry_t;

    logic [7:0] mem [DEPTH_BYTES];

    entry_t     entries_q [2];
    entry_t     entries_d [2];
    logic [1:0] count_q, count_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;

    logic          push, pop;
    logic [XLEN:0] fetch_off;
    logic          misaligned, out_of_range;
    logic [1:0]    new_fault;
    logic [XLEN-1:0] rd_instr;

    assign fetch_ready = rst_n & ~flush & (count_q < 2'd2);
    assign push        = fetch_valid & fetch_ready;
    assign pop         = resp_valid & resp_ready & ~flush;

    // Offset is formed one bit wider so addresses near the top of the space cannot wrap into range.
    assign fetch_off    = {1'b0, fetch_addr} - BASE_X;
    assign misaligned   = ALIGN_CHECK && ((fetch_addr % XLEN'(NB)) != '0);
    assign out_of_range = ({1'b0, fetch_addr} < BASE_X) || (fetch_off > LAST_X);
    assign new_fault    = misaligned   ? FAULT_ALIGN :
                          out_of_range ? FAULT_RANGE : FAULT_OK;

    // Combinational read sees the array before this edge's load, giving read-before-write.
    always_comb begin
        rd_instr = '0;
        if (new_fault == FAULT_OK) begin
            for (int i = 0; i < NB; i++) begin
                rd_instr[8*i +: 8] = mem[fetch_off[IDX_W-1:0] + IDX_W'(i)];
            end
        end
    end

    logic [XLEN:0] lane_addr [NB];
    logic [NB-1:0] lane_we;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            lane_addr[i] = {1'b0, load_addr} + (XLEN+1)'(i) - BASE_X;
            lane_we[i]   = load_en && load_be[i] &&
                           ({1'b0, load_addr} + (XLEN+1)'(i) >= BASE_X) &&
                           (lane_addr[i] < DEPTH_X);
        end
    end

    // NOTE: storage has no reset so it maps onto RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (lane_we[i]) begin
                mem[lane_addr[i][IDX_W-1:0]] <= load_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                entries_d[wr_ptr_q] = '{instr: rd_instr, addr: fetch_addr, fault: new_fault};
                wr_ptr_d            = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            entries_q <= entries_d;
        end
    end

    assign resp_valid = (count_q != 2'd0);
    assign resp_instr = entries_q[rd_ptr_q].instr;
    assign resp_addr  = entries_q[rd_ptr_q].addr;
    assign resp_fault = entries_q[rd_ptr_q].fault;

endmodule
